// File: rtl/fetch_prefetch_unit_if.sv
// Fetch unit bus bundle: redirect input, instruction-memory request/response and IF/ID output.
// The master modport is the fetch unit; slave is its environment.
interface fetch_prefetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order memory requests under a credit
// limit, buffers {pc, inst} in a small FIFO and discards wrong-path responses after redirects.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_prefetch_unit_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] iss_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   credit_used;
  logic [CW:0]   drop_base;
  logic [CW:0]   drop_sum;
  logic          issue;
  logic          xfer;
  logic          accept;
  logic          pop;

  // Issue credit, response acceptance and the redirect drop tally
  always_comb begin
    credit_used = {1'b0, count} + {1'b0, outstanding};
    issue       = (state == FETCH) && (credit_used < (CW+1)'(DEPTH)) &&
                  !bus.redirect_valid && !rst;
    xfer        = issue && bus.imem_ready;
    accept      = (state == FETCH) && bus.imem_rvalid && (outstanding != '0) &&
                  !bus.redirect_valid && !rst;
    pop         = bus.out_valid && bus.out_ready;
    drop_base   = {1'b0, outstanding} + {1'b0, drop_cnt};
    drop_sum    = drop_base;
    if (bus.imem_rvalid && (drop_base != '0)) begin
      drop_sum = drop_base - (CW+1)'(1);
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;
  assign bus.out_valid = (count != '0) && !bus.redirect_valid && !rst;
  assign bus.out_pc    = rst ? 32'h0 : fifo_pc[rd_ptr];
  assign bus.out_inst  = rst ? 32'h0 : fifo_inst[rd_ptr];

  // Each request reserves its slot at issue time, so the pc column doubles as the tag queue
  always_ff @(posedge clk) begin
    if (xfer) begin
      fifo_pc[iss_ptr] <= pc;
    end
    if (accept) begin
      fifo_inst[wr_ptr] <= bus.imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      iss_ptr     <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (bus.redirect_valid) begin
      pc          <= bus.redirect_pc;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      iss_ptr     <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= CW'(drop_sum);
      state       <= (drop_sum != '0) ? DRAIN : FETCH;
    end else begin
      if (xfer) begin
        pc      <= pc + 32'd4;
        iss_ptr <= iss_ptr + AW'(1);
      end
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count       <= count + CW'(accept) - CW'(pop);
      outstanding <= outstanding + CW'(xfer) - CW'(accept);
      // Stale responses are swallowed; the last one returns the unit to FETCH
      if ((state == DRAIN) && bus.imem_rvalid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
        if (drop_cnt == CW'(1)) begin
          state <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized scoreboard bench for fetch_prefetch_unit: in-order variable-latency memory model,
// expected fetch stream rebuilt from redirect/reset targets, request-side protocol rules.
module tb_fetch_prefetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_prefetch_unit_if bus ();

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_pop  = 0;
  int n_xfer = 0;

  // memory model state
  int          lat_min  = 1;
  int          lat_max  = 1;
  bit          rdy_rand = 1'b0;
  req_t        pend[$];
  int          last_due = 0;
  int          stale    = 0;
  logic [31:0] next_req_pc = RESET_PC;
  bit          want_issue   = 1'b0;
  bit          drained_prev = 1'b0;
  bit          prev_stall   = 1'b0;
  bit          prev_rst     = 1'b0;
  bit          prev_redir   = 1'b0;
  logic [31:0] stall_addr   = '0;
  logic [31:0] redir_pc_q   = '0;

  // expected output stream
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail = RESET_PC;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory response driver: one in-order response per cycle once its latency has elapsed
  always @(posedge clk) begin
    #1;
    bus.imem_ready = rdy_rand ? ($urandom_range(0, 99) < 70) : 1'b1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = inst_of(pend[0].addr);
      void'(pend.pop_front());
      if (stale > 0) stale--;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
  end

  // Request side: accept transfers and check issue rules
  always @(negedge clk) begin
    if (rst) begin
      check("req_in_reset", 32'(bus.imem_req), 32'd0);
      pend.delete();
      stale        = 0;
      last_due     = 0;
      n_xfer       = 0;
      next_req_pc  = RESET_PC;
      want_issue   = 1'b1;
      drained_prev = 1'b1;
      prev_stall   = 1'b0;
      prev_redir   = 1'b0;
      prev_rst     = 1'b1;
    end else begin
      if (prev_rst)   check("addr_after_reset", bus.imem_addr, RESET_PC);
      if (prev_redir) check("addr_after_redirect", bus.imem_addr, redir_pc_q);
      if (prev_stall) check("addr_stable", bus.imem_addr, stall_addr);
      if (stale > 0)  check("no_issue_while_draining", 32'(bus.imem_req), 32'd0);
      if (bus.redirect_valid) begin
        check("no_issue_on_redirect", 32'(bus.imem_req), 32'd0);
        stale       = pend.size();
        next_req_pc = bus.redirect_pc;
        redir_pc_q  = bus.redirect_pc;
        want_issue  = 1'b1;
        prev_redir  = 1'b1;
        prev_stall  = 1'b0;
      end else begin
        if (want_issue && drained_prev) check("issue_when_idle", 32'(bus.imem_req), 32'd1);
        if (bus.imem_req) want_issue = 1'b0;
        if (bus.imem_req && bus.imem_ready) begin
          int lat;
          int due;
          check("req_addr", bus.imem_addr, next_req_pc);
          next_req_pc = next_req_pc + 32'd4;
          n_xfer++;
          lat = $urandom_range(lat_min, lat_max);
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{addr: bus.imem_addr, due: due});
        end
        prev_stall = bus.imem_req && !bus.imem_ready;
        stall_addr = bus.imem_addr;
        prev_redir = 1'b0;
      end
      prev_rst     = 1'b0;
      drained_prev = (stale == 0);
    end
  end

  // Output monitor: pops the scoreboard on every accepted instruction
  always @(negedge clk) begin
    if (rst) begin
      check("out_valid_in_reset", 32'(bus.out_valid), 32'd0);
      check("out_pc_in_reset", bus.out_pc, 32'd0);
      check("out_inst_in_reset", bus.out_inst, 32'd0);
    end else if (bus.redirect_valid) begin
      check("out_valid_in_redirect", 32'(bus.out_valid), 32'd0);
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got pc %h expected nothing", bus.out_pc);
      end else begin
        check("out_pc", bus.out_pc, exp_q[0]);
        check("out_inst", bus.out_inst, inst_of(exp_q[0]));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
  end

  // One cycle of stimulus; resets and redirects restart the expected stream
  task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic ordy);
    @(posedge clk);
    #1;
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rv ? rp : $urandom;
    bus.out_ready      = ordy;
    if (r) begin
      exp_q.delete();
      exp_tail = RESET_PC;
    end else if (rv) begin
      exp_q.delete();
      exp_tail = rp;
    end
    while (exp_q.size() < 16) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd4;
    end
  endtask

  initial begin
    int first_valid;
    int valid_cycles;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    bus.imem_ready     = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;

    // streaming at one instruction per cycle, first valid two cycles after reset
    lat_min = 1; lat_max = 1; rdy_rand = 1'b0;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    first_valid  = -1;
    valid_cycles = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      if (bus.out_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = k;
      end
    end
    check("first_valid_latency", 32'(first_valid), 32'd2);
    check("stream_valid_cycles", 32'(valid_cycles), 32'd10);

    // stalled consumer: exactly DEPTH requests then back-pressure
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("stall_req_count", 32'(n_xfer), 32'(DEPTH));
    check("stall_req_low", 32'(bus.imem_req), 32'd0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // redirect coinciding with a response, one outstanding
    step(1'b0, 1'b1, 32'h300, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("direct_fetch_req", 32'(bus.imem_req), 32'd1);
    check("direct_fetch_addr", bus.imem_addr, 32'h300);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // latency 3: redirect with responses in flight, then a redirect during the drain
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    for (int k = 0; k < 15; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    for (int k = 0; k < 15; k++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // reset with a filling FIFO and requests in flight
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // randomized traffic, including PC wrap-around targets
    lat_min = 1; lat_max = 4; rdy_rand = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      logic        r;
      logic        rv;
      logic [31:0] rp;
      r  = ($urandom_range(0, 999) < 4);
      rv = !r && ($urandom_range(0, 99) < 5);
      rp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
      step(r, rv, rp, $urandom_range(0, 99) < 75);
    end
    for (int k = 0; k < 30; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("progress", 32'(n_pop > 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
